dec416_strobe: RTL



---
 rtl/dec416_pkg.sv | 20 ++
 rtl/dec416_timer.sv | 26 ++
 rtl/dec416_strobe.sv | 99 +++++++++
 3 files changed

// File: rtl/dec416_pkg.sv
// Shared types and helpers for the 4-to-16 strobe decoder.
// Pure definitions: no logic, no latency, no flow control.
package dec416_pkg;

  localparam int IDX_W = 4;
  localparam int OUT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // en=0 is the encoder's "no line" case and decodes to all-zero
  function automatic logic [OUT_W-1:0] onehot16(input logic [IDX_W-1:0] idx,
                                                input logic             en);
    return en ? (OUT_W'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/dec416_timer.sv
// Loadable down-counter shared by the DRIVE and GAP phases; load wins, 0-cycle latency on zero.
// Counts down by one every cycle until it reaches zero, then holds; no backpressure.
module dec416_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (!zero) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/dec416_strobe.sv
// Sequential 4-to-16 decoder: accepted index appears as a registered one-hot strobe 1 cycle later,
// held PULSE_LEN cycles plus GAP_LEN zero cycles; in_ready low while a slot is in flight. Option: DEC416_XFER_COUNT_EN.
import dec416_pkg::*;

module dec416_strobe #(
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_en,
  output logic [OUT_W-1:0] y,
  output logic             busy
`ifdef DEC416_XFER_COUNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  state_t           state, state_nxt;
  logic [OUT_W-1:0] y_nxt;
  logic             accept;
  logic             t_load;
  logic [CNT_W-1:0] t_load_val;
  logic [CNT_W-1:0] t_val;
  logic             t_zero;

  dec416_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_load_val),
    .value    (t_val),
    .zero     (t_zero)
  );

  // Last DRIVE cycle may take a new index when there is no gap, giving seamless strobes
  assign in_ready = !rst && ((state == IDLE) ||
                             (state == DRIVE && t_val == '0 && GAP_LEN == 0));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    y_nxt      = y;
    t_load     = 1'b0;
    t_load_val = CNT_W'(PULSE_LEN - 1);
    if (accept) begin
      state_nxt = DRIVE;
      y_nxt     = onehot16(in_idx, in_en);
      t_load    = 1'b1;
    end else begin
      case (state)
        DRIVE: begin
          if (t_zero) begin
            y_nxt = '0;
            if (GAP_LEN > 0) begin
              state_nxt  = GAP;
              t_load     = 1'b1;
              t_load_val = CNT_W'(GAP_LEN - 1);
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        GAP: begin
          if (t_zero) state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      y     <= '0;
    end else begin
      state <= state_nxt;
      y     <= y_nxt;
    end
  end

`ifdef DEC416_XFER_COUNT_EN
  // Bubbles (en=0) are real transfers and are counted too
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (accept) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule
